// File: rtl/color_bar_timing_gen_pkg.sv
// color_bar_timing_gen_pkg: shared 640x480 timing defaults, bar colours and state encoding.
package color_bar_timing_gen_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COL_GREEN   = 24'h00FF00;
    localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COL_RED     = 24'hFF0000;
    localparam logic [23:0] COL_BLUE    = 24'h0000FF;
    localparam logic [23:0] COL_BLACK   = 24'h000000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return COL_WHITE;
            3'd1:    return COL_YELLOW;
            3'd2:    return COL_CYAN;
            3'd3:    return COL_GREEN;
            3'd4:    return COL_MAGENTA;
            3'd5:    return COL_RED;
            3'd6:    return COL_BLUE;
            default: return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/color_bar_timing_gen_video_timing_counter.sv
// video_timing_counter: h/v raster counters with raw (unregistered, positive-true) sync/de decode
// and line/frame end flags; counters are held at zero while i_run is low.
module video_timing_counter
    import color_bar_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             i_run,
    output logic [CNT_W-1:0] o_h_cnt,
    output logic [CNT_W-1:0] o_v_cnt,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic             o_h_last,
    output logic             o_frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last;

    always_comb begin
        h_last  = h_cnt_q == CNT_W'(H_TOTAL - 1);
        v_last  = v_cnt_q == CNT_W'(V_TOTAL - 1);
        h_cnt_d = (!i_run || h_last) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = !i_run ? '0 : h_last ? (v_last ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign o_h_cnt     = h_cnt_q;
    assign o_v_cnt     = v_cnt_q;
    assign o_h_last    = h_last;
    assign o_frame_end = h_last && v_last;
    assign o_hs        = (h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) && (h_cnt_q < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign o_vs        = (v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) && (v_cnt_q < CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    assign o_de        = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/color_bar_timing_gen.sv
// color_bar_timing_gen: frame-gated 8-bar colour test-pattern video source with registered outputs.
// Define COLOR_BAR_SCROLL_EN to rotate the bars by one position per frame.
module color_bar_timing_gen
    import color_bar_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             i_en,
    output logic             o_hs,
    output logic             o_vs,
    output logic             o_de,
    output logic [23:0]      o_data,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACTIVE / 8 - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             t_hs, t_vs, t_de, h_last, frame_end, run;
    logic [CNT_W-1:0] px_q, px_d;
    logic [2:0]       bar_q, bar_d, bar_idx;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [23:0]      data_q, data_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

    assign run = state_q != IDLE;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .i_run       (run),
        .o_h_cnt     (h_cnt),
        .o_v_cnt     (v_cnt),
        .o_hs        (t_hs),
        .o_vs        (t_vs),
        .o_de        (t_de),
        .o_h_last    (h_last),
        .o_frame_end (frame_end)
    );

    // RUN and STOPPING differ only in what happens at the frame end, so they share one rule.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          state_d = i_en ? RUN : IDLE;
            RUN, STOPPING: state_d = i_en ? RUN : (frame_end ? IDLE : STOPPING);
            default:       state_d = IDLE;
        endcase
    end

    always_comb begin
        px_d  = (!run || h_last || px_q == BAR_LAST) ? '0 : px_q + 1'b1;
        bar_d = (!run || h_last) ? 3'd0 : (px_q == BAR_LAST) ? bar_q + 3'd1 : bar_q;
    end

`ifdef COLOR_BAR_SCROLL_EN
    logic [2:0] frame_q, frame_d;

    always_comb begin
        frame_d = (state_d == IDLE) ? 3'd0 : (run && frame_end) ? frame_q + 3'd1 : frame_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            frame_q <= 3'd0;
        end else begin
            frame_q <= frame_d;
        end
    end

    assign bar_idx = bar_q + frame_q;
`else
    assign bar_idx = bar_q;
`endif

    always_comb begin
        de_d   = run && t_de;
        hs_d   = (run && t_hs) ? HS_POL : ~HS_POL;
        vs_d   = (run && t_vs) ? VS_POL : ~VS_POL;
        data_d = de_d ? bar_color(bar_idx) : 24'h0;
        x_d    = de_d ? h_cnt : x_q;
        y_d    = de_d ? v_cnt : y_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            px_q    <= '0;
            bar_q   <= 3'd0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            data_q  <= 24'h0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            bar_q   <= bar_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            data_q  <= data_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign o_hs   = hs_q;
    assign o_vs   = vs_q;
    assign o_de   = de_q;
    assign o_data = data_q;
    assign o_x    = x_q;
    assign o_y    = y_q;
    assign o_busy = run;

endmodule
